// File: rtl/scoot_arena.sv
// -----------------------------------------------------------------------------
// scoot_arena
//
// A small "food collecting" arena. A WIDTH x HEIGHT bit map, toroidal in both
// axes, holds food. An external bot is shown its four neighbour cells and is
// then given STEP_CYCLES cycles to raise move requests. The arena then applies
// the move. Food under the bot is collected and cleared when the bot arrives
// on a cell. One run lasts NUM_STEPS moves.
//
// Per-step timing: VISIT (1 cycle) -> WAIT (STEP_CYCLES cycles) -> MOVE (1).
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   load_en, load_x, load_row      write one map column (bit y = cell x,y);
//                                  accepted only in IDLE or DONE
//   start                          begin a run (accepted only in IDLE or DONE)
//   m_up/m_right/m_down/m_left     move requests, sampled only in MOVE
//   l_up/l_right/l_down/l_left     registered neighbour food sensors
//   step_valid                     sensors valid, moves awaited (WAIT)
//   pickup                         one-cycle pulse when food is collected
//   pos_x, pos_y                   bot position
//   score, step_count              food collected / moves done this run
//   busy, done                     run in progress / run finished
// -----------------------------------------------------------------------------
module scoot_arena #(
  parameter int WIDTH       = 10,
  parameter int HEIGHT      = 10,
  parameter int NUM_STEPS   = 100,
  parameter int STEP_CYCLES = 4,
  localparam int XW = ($clog2(WIDTH)  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = ($clog2(HEIGHT) > 1) ? $clog2(HEIGHT) : 1,
  localparam int SW = $clog2(WIDTH * HEIGHT + 1),
  localparam int NW = $clog2(NUM_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [XW-1:0]     load_x,
  input  logic [HEIGHT-1:0] load_row,
  input  logic              start,
  input  logic              m_up,
  input  logic              m_right,
  input  logic              m_down,
  input  logic              m_left,
  output logic              l_up,
  output logic              l_right,
  output logic              l_down,
  output logic              l_left,
  output logic              step_valid,
  output logic              pickup,
  output logic [XW-1:0]     pos_x,
  output logic [YW-1:0]     pos_y,
  output logic [SW-1:0]     score,
  output logic [NW-1:0]     step_count,
  output logic              busy,
  output logic              done
);

  localparam int CW = ($clog2(STEP_CYCLES) > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VISIT,
    WAIT,
    MOVE,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic [HEIGHT-1:0] map [WIDTH];

  // Wrapped neighbour coordinates of the current position.
  logic [XW-1:0] x_inc, x_dec, x_next;
  logic [YW-1:0] y_inc, y_dec, y_next;

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    x_inc = (pos_x == XW'(WIDTH - 1))  ? '0 : pos_x + XW'(1);
    x_dec = (pos_x == '0) ? XW'(WIDTH - 1)  : pos_x - XW'(1);
    y_inc = (pos_y == YW'(HEIGHT - 1)) ? '0 : pos_y + YW'(1);
    y_dec = (pos_y == '0) ? YW'(HEIGHT - 1) : pos_y - YW'(1);

    // Opposing requests cancel, so only a lone request in an axis moves.
    x_next = pos_x;
    if (m_right && !m_left)      x_next = x_inc;
    else if (m_left && !m_right) x_next = x_dec;

    y_next = pos_y;
    if (m_up && !m_down)         y_next = y_inc;
    else if (m_down && !m_up)    y_next = y_dec;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      l_up       <= 1'b0;
      l_right    <= 1'b0;
      l_down     <= 1'b0;
      l_left     <= 1'b0;
      step_valid <= 1'b0;
      pickup     <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      score      <= '0;
      step_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      // NOTE: the map is a flop array, not a RAM, because reset must clear
      // every cell at once; a RAM macro could not be reset this way.
      for (int i = 0; i < WIDTH; i++) map[i] <= '0;
    end else begin
      pickup <= 1'b0;

      unique case (state)
        IDLE, DONE: begin
          if (load_en && (int'(load_x) < WIDTH)) map[load_x] <= load_row;
          if (start) begin
            pos_x      <= XW'(WIDTH / 2);
            pos_y      <= YW'(HEIGHT / 2);
            score      <= '0;
            step_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= VISIT;
          end
        end

        VISIT: begin
          if (map[pos_x][pos_y]) begin
            map[pos_x][pos_y] <= 1'b0;
            score             <= score + SW'(1);
            pickup            <= 1'b1;
          end
          l_up       <= map[pos_x][y_inc];
          l_down     <= map[pos_x][y_dec];
          l_right    <= map[x_inc][pos_y];
          l_left     <= map[x_dec][pos_y];
          wait_cnt   <= '0;
          step_valid <= 1'b1;
          state      <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == CW'(STEP_CYCLES - 1)) begin
            step_valid <= 1'b0;
            state      <= MOVE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        MOVE: begin
          pos_x      <= x_next;
          pos_y      <= y_next;
          step_count <= step_count + NW'(1);
          // The final position is not visited: the run ends on this move.
          if (step_count == NW'(NUM_STEPS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= VISIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
